uart_debug_host: RTL
====================

Name: uart_debug_host

Overview:
Host-side initiator for the UART debug protocol. It accepts one debug command at a time over a valid/ready request port and serialises it into a request frame on a byte stream. It then parses the target's response frame, checks it, and returns status or read data on a result port. It sits in front of a UART TX/RX byte pair, in a host FPGA or a system-level bench, driving the on-target debug bus master.

Parameters:
TIMEOUT_CYCLES, 100000, clk cycles with no accepted rx byte while awaiting a response before aborting; counter width is $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  input  1  clock; the block has one clock
rst  input  1  reset; synchronous, active-high
cmd_valid  input  1  command request valid
cmd_ready  output  1  high only in IDLE
cmd_code  input  8  0x10 WR32, 0x11 RD32, 0x12 RUN, 0x13 HALT, 0x14 RDREG
cmd_addr  input  32  address (WR32/RD32)
cmd_wdata  input  32  write data (WR32)
cmd_reg  input  5  register index (RDREG)
tx_data  output  8  request byte to UART TX
tx_valid  output  1  tx_data valid
tx_ready  input  1  UART TX accepts byte
rx_data  input  8  response byte from UART RX
rx_valid  input  1  rx_data valid
rx_ready  output  1  constant 1; every byte is consumed
rsp_valid  output  1  one-cycle result pulse
rsp_err  output  3  0 NONE, 1 CHK, 2 TIMEOUT, 3 TYPE, 4 CMD
rsp_status  output  8  ACK status byte (00 OK, 01 CHK, 02 BUSY, 03 CMD); 0 if not an ACK
rsp_data  output  32  read data from 0x91/0x92 responses; 0 otherwise
busy  output  1  high when not IDLE

Behaviour:
- Byte transfer rule: a byte moves when valid&&ready on the same edge. tx_data is stable while tx_valid=1 && tx_ready=0.
- Reset: tx_valid=0, tx_data=0, rsp_valid=0, rsp_err=0, rsp_status=0, rsp_data=0, state=IDLE. A reset mid-frame abandons the frame immediately; no partial result is emitted.
- Request frames (CHK = XOR of every byte after A5; little-endian fields):
  - WR32: A5 10 A0 A1 A2 A3 D0 D1 D2 D3 CHK
  - RD32: A5 11 A0..A3 CHK
  - RUN: A5 12 12
  - HALT: A5 13 13
  - RDREG: A5 14 {3'b0,idx} CHK
- States: IDLE, SEND, WAIT_RSOF, RTYPE, RPAY, RCHK.
- IDLE:
  - On cmd_valid&&cmd_ready, latch inputs and build the frame into an 11-byte buffer with its frame length.
  - Unknown cmd_code: no bytes are sent; rsp_valid pulses next cycle with err=4 (CMD); stay in IDLE.
- SEND:
  - The first byte (A5) is driven with tx_valid=1 in the cycle after cmd acceptance.
  - The next byte is presented the cycle after each handshake, allowing back-to-back bytes when tx_ready stays high.
  - After the last byte's handshake: tx_valid=0, timeout counter cleared, go to WAIT_RSOF.
- WAIT_RSOF: discard bytes until 0x5A, then go to RTYPE.
- RTYPE:
  - 0x90 is accepted for any command; expect 1 payload byte.
  - 0x91 is accepted only for RD32; 0x92 only for RDREG; each expects 4 payload bytes.
  - Any other type byte: rsp err=3 (TYPE), return to IDLE.
  - The running checksum is seeded with the type byte.
- RPAY: accumulate payload bytes, XORing each into the checksum. Bytes are little-endian into rsp_data.
- RCHK:
  - A CHK byte that mismatches the running checksum gives err=1 (CHK).
  - Otherwise err=0, with rsp_status or rsp_data loaded.
  - rsp_valid pulses the cycle after CHK is accepted; rsp_* fields hold until the next result.
- Bytes received in IDLE or SEND are dropped.
- Timeout:
  - Active in WAIT_RSOF, RTYPE, RPAY and RCHK; the counter clears on every accepted rx byte.
  - When the count reaches TIMEOUT_CYCLES: rsp err=2, rsp_status and rsp_data = 0, back to IDLE.
- If a byte arrives in the same cycle the timeout expires, the byte wins and the counter clears.
- cmd_ready reasserts in the cycle rsp_valid pulses, so the next command may be accepted in that cycle.

Test Plan:
- WR32 addr 0x00001000, data 0xDEADBEEF, tx_ready=1 -> tx bytes A5 10 00 10 00 00 EF BE AD DE 22 on 11 consecutive cycles. Then rx 5A 90 00 90 -> rsp_valid, err=0, status=00.
- RD32 addr 0x4 -> tx A5 11 04 00 00 00 15. Then rx FF 5A 91 78 56 34 12 99 -> leading FF discarded, err=0, rsp_data=0x12345678.
- RUN -> tx A5 12 12. Then rx 5A 90 00 91 -> err=1 (CHK).
- RDREG idx 5 -> tx A5 14 05 11. Then rx 5A 91 ... -> err=3 (TYPE). Second case: rx 5A 90 02 92 -> err=0, status=02 (BUSY).
- TIMEOUT_CYCLES=64, HALT (A5 13 13), no response -> rsp_valid exactly 64 cycles after the last tx handshake, err=2. cmd_code 0x20 -> no tx activity, err=4 next cycle.
- Random tx_ready backpressure during WR32 -> tx_data stable while stalled and byte sequence unchanged. Assert rst after the 4th byte -> tx_valid=0 next cycle, no rsp_valid, cmd_ready=1.

Source files
------------

// File: rtl/uart_debug_host.sv
// uart_debug_host
// Host-side initiator for the UART debug protocol. It takes one command at a
// time on a valid/ready request port and serialises it into a request frame on
// the tx byte stream. It then parses the target's response frame, verifies its
// checksum and returns status or read data on the result port.
//
// Ports:
//   clk, rst                    single clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (ready only while idle)
//   cmd_code/addr/wdata/reg     command fields (0x10 WR32 .. 0x14 RDREG)
//   tx_data/tx_valid/tx_ready   request byte stream to the UART transmitter
//   rx_data/rx_valid/rx_ready   response byte stream from the UART receiver
//   rsp_valid                   one-cycle result pulse
//   rsp_err/rsp_status/rsp_data result fields, held until the next result
//   busy                        high whenever a command is in flight
module uart_debug_host #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_code,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [4:0]  cmd_reg,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        rsp_valid,
  output logic [2:0]  rsp_err,
  output logic [7:0]  rsp_status,
  output logic [31:0] rsp_data,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_RSOF, RTYPE, RPAY, RCHK} state_t;

  // XOR of the four bytes of a word, used for frame checksums.
  function automatic logic [7:0] xor_bytes(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

  state_t        state_r, state_next_s;
  logic [7:0]    frame_s [0:10];
  logic [3:0]    flen_s;
  logic          code_ok_s;
  logic [7:0]    frame_r [0:10];
  logic [3:0]    flen_r;
  logic [3:0]    idx_r;
  logic [7:0]    code_r;
  logic [TW-1:0] tcnt_r;
  logic [7:0]    chk_r;
  logic [31:0]   acc_r;
  logic [1:0]    pay_cnt_r;
  logic [1:0]    pay_last_r;
  logic          is_ack_r;

  logic cmd_fire_s, tx_fire_s, last_byte_s, waiting_s, tout_s, type_ok_s;

  assign cmd_ready   = (state_r == IDLE);
  assign busy        = (state_r != IDLE);
  assign rx_ready    = 1'b1;
  assign cmd_fire_s  = cmd_valid && cmd_ready;
  assign tx_fire_s   = tx_valid && tx_ready;
  assign last_byte_s = (idx_r == flen_r - 4'd1);
  assign waiting_s   = (state_r == WAIT_RSOF) || (state_r == RTYPE) ||
                       (state_r == RPAY) || (state_r == RCHK);
  // An arriving byte always beats an expiring timeout.
  assign tout_s      = waiting_s && !rx_valid && (tcnt_r == TW'(TIMEOUT_CYCLES - 1));
  assign type_ok_s   = (rx_data == 8'h90) ||
                       ((rx_data == 8'h91) && (code_r == 8'h11)) ||
                       ((rx_data == 8'h92) && (code_r == 8'h14));

  // Build the request frame for the presented command.
  always_comb begin
    for (int i = 0; i < 11; i++) frame_s[i] = 8'h00;
    flen_s     = 4'd0;
    code_ok_s  = 1'b1;
    frame_s[0] = 8'hA5;
    frame_s[1] = cmd_code;
    case (cmd_code)
      8'h10: begin
        {frame_s[5], frame_s[4], frame_s[3], frame_s[2]} = cmd_addr;
        {frame_s[9], frame_s[8], frame_s[7], frame_s[6]} = cmd_wdata;
        frame_s[10] = 8'h10 ^ xor_bytes(cmd_addr) ^ xor_bytes(cmd_wdata);
        flen_s      = 4'd11;
      end
      8'h11: begin
        {frame_s[5], frame_s[4], frame_s[3], frame_s[2]} = cmd_addr;
        frame_s[6] = 8'h11 ^ xor_bytes(cmd_addr);
        flen_s     = 4'd7;
      end
      8'h12, 8'h13: begin
        frame_s[2] = cmd_code;
        flen_s     = 4'd3;
      end
      8'h14: begin
        frame_s[2] = {3'b000, cmd_reg};
        frame_s[3] = 8'h14 ^ {3'b000, cmd_reg};
        flen_s     = 4'd4;
      end
      default: code_ok_s = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_fire_s && code_ok_s) state_next_s = SEND;
        else                         state_next_s = IDLE;
      end
      SEND: begin
        if (tx_fire_s && last_byte_s) state_next_s = WAIT_RSOF;
        else                          state_next_s = SEND;
      end
      WAIT_RSOF: begin
        if (rx_valid && (rx_data == 8'h5A)) state_next_s = RTYPE;
        else if (tout_s)                    state_next_s = IDLE;
        else                                state_next_s = WAIT_RSOF;
      end
      RTYPE: begin
        if (rx_valid)    state_next_s = type_ok_s ? RPAY : IDLE;
        else if (tout_s) state_next_s = IDLE;
        else             state_next_s = RTYPE;
      end
      RPAY: begin
        if (rx_valid && (pay_cnt_r == pay_last_r)) state_next_s = RCHK;
        else if (tout_s)                           state_next_s = IDLE;
        else                                       state_next_s = RPAY;
      end
      RCHK: begin
        if (rx_valid || tout_s) state_next_s = IDLE;
        else                    state_next_s = RCHK;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register, tx serialiser, rx parser and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      rsp_valid  <= 1'b0;
      rsp_err    <= 3'd0;
      rsp_status <= 8'h00;
      rsp_data   <= 32'h0;
      for (int i = 0; i < 11; i++) frame_r[i] <= 8'h00;
      flen_r     <= 4'd0;
      idx_r      <= 4'd0;
      code_r     <= 8'h00;
      tcnt_r     <= '0;
      chk_r      <= 8'h00;
      acc_r      <= 32'h0;
      pay_cnt_r  <= 2'd0;
      pay_last_r <= 2'd0;
      is_ack_r   <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      rsp_valid <= 1'b0;
      if (waiting_s) begin
        if (rx_valid) tcnt_r <= '0;
        else          tcnt_r <= tcnt_r + TW'(1);
        if (tout_s) begin
          rsp_valid  <= 1'b1;
          rsp_err    <= 3'd2;
          rsp_status <= 8'h00;
          rsp_data   <= 32'h0;
        end
      end
      case (state_r)
        IDLE: begin
          if (cmd_fire_s) begin
            if (code_ok_s) begin
              frame_r  <= frame_s;
              flen_r   <= flen_s;
              code_r   <= cmd_code;
              idx_r    <= 4'd0;
              tx_valid <= 1'b1;
              tx_data  <= frame_s[0];
            end else begin
              rsp_valid  <= 1'b1;
              rsp_err    <= 3'd4;
              rsp_status <= 8'h00;
              rsp_data   <= 32'h0;
            end
          end
        end
        SEND: begin
          if (tx_fire_s) begin
            if (last_byte_s) begin
              tx_valid <= 1'b0;
              tcnt_r   <= '0;
            end else begin
              idx_r   <= idx_r + 4'd1;
              tx_data <= frame_r[idx_r + 4'd1];
            end
          end
        end
        RTYPE: begin
          if (rx_valid) begin
            if (type_ok_s) begin
              chk_r      <= rx_data;
              is_ack_r   <= (rx_data == 8'h90);
              pay_last_r <= (rx_data == 8'h90) ? 2'd0 : 2'd3;
              pay_cnt_r  <= 2'd0;
              acc_r      <= 32'h0;
            end else begin
              rsp_valid  <= 1'b1;
              rsp_err    <= 3'd3;
              rsp_status <= 8'h00;
              rsp_data   <= 32'h0;
            end
          end
        end
        RPAY: begin
          if (rx_valid) begin
            chk_r                          <= chk_r ^ rx_data;
            acc_r[{pay_cnt_r, 3'b000} +: 8] <= rx_data;
            pay_cnt_r                      <= pay_cnt_r + 2'd1;
          end
        end
        RCHK: begin
          if (rx_valid) begin
            rsp_valid <= 1'b1;
            if (rx_data != chk_r) begin
              rsp_err    <= 3'd1;
              rsp_status <= 8'h00;
              rsp_data   <= 32'h0;
            end else begin
              rsp_err    <= 3'd0;
              rsp_status <= is_ack_r ? acc_r[7:0] : 8'h00;
              rsp_data   <= is_ack_r ? 32'h0 : acc_r;
            end
          end
        end
        default: begin
          // WAIT_RSOF only discards bytes; the timeout is handled above.
        end
      endcase
    end
  end

endmodule
